// File: rtl/mio_pkg.sv
// mio_pkg: shared constants for the memory-mapped I/O bus.
//   - I/O register offsets inside the 256-byte window
//   - CTRL and STATUS bit positions
//   - default base address of the I/O window
package mio_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

  // Word-aligned register offsets (address bits [7:0], with [1:0] forced to 0)
  localparam logic [7:0] OFF_LED       = 8'h00;
  localparam logic [7:0] OFF_SW        = 8'h04;
  localparam logic [7:0] OFF_CNT_LOAD  = 8'h08;
  localparam logic [7:0] OFF_CNT_VALUE = 8'h0C;
  localparam logic [7:0] OFF_CTRL      = 8'h10;
  localparam logic [7:0] OFF_STATUS    = 8'h14;

  // CTRL register bits
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_BITS        = 3;

  // STATUS register bits (write 1 to clear)
  localparam int STAT_DONE    = 0;
  localparam int STAT_BUS_ERR = 1;

endpackage

// File: rtl/mio_counter.sv
// mio_counter: reloadable down-counter with sticky done flag.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_load_we        CNT_LOAD write strobe: loads both cnt_load and cnt_value
//   i_load_data      value written to CNT_LOAD
//   i_en             count enable (registered CTRL.en)
//   i_auto_reload    reload from cnt_load on wrap instead of stopping at 0
//   i_done_clr       W1C clear of the done flag
//   o_cnt_value      current count
//   o_cnt_load       reload value
//   o_done           sticky done flag
module mio_counter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load_we,
  input  logic [31:0] i_load_data,
  input  logic        i_en,
  input  logic        i_auto_reload,
  input  logic        i_done_clr,
  output logic [31:0] o_cnt_value,
  output logic [31:0] o_cnt_load,
  output logic        o_done
);

  logic [31:0] r_cnt_value;
  logic [31:0] r_cnt_load;
  logic        r_done;
  logic        w_wrap;

  // A load on the same edge replaces the tick entirely, so it also suppresses
  // the done set that the 1 -> 0/reload transition would otherwise cause.
  assign w_wrap = i_en && !i_load_we && (r_cnt_value == 32'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt_value <= '0;
      r_cnt_load  <= '0;
      r_done      <= 1'b0;
    end else begin
      if (i_load_we) begin
        r_cnt_load  <= i_load_data;
        r_cnt_value <= i_load_data;
      end else if (i_en) begin
        if (r_cnt_value > 32'd1) begin
          r_cnt_value <= r_cnt_value - 32'd1;
        end else if (r_cnt_value == 32'd1) begin
          r_cnt_value <= i_auto_reload ? r_cnt_load : 32'd0;
        end
        // value 0: hold, no underflow
      end

      // Set has priority over the W1C clear on the same edge.
      if (w_wrap) begin
        r_done <= 1'b1;
      end else if (i_done_clr) begin
        r_done <= 1'b0;
      end
    end
  end

  assign o_cnt_value = r_cnt_value;
  assign o_cnt_load  = r_cnt_load;
  assign o_done      = r_done;

endmodule

// File: rtl/mio_bus.sv
// mio_bus: memory-mapped I/O bus downstream of the MEM stage.
// Decodes each access to data RAM, the I/O register window, or unmapped
// space, and returns load data combinationally in the same cycle.
// Ports:
//   clk, rst    CPU clock, synchronous active-high reset
//   cpu_we      MEM-stage store strobe
//   cpu_addr    byte address (bits [1:0] ignored)
//   cpu_wdata   store data
//   cpu_rdata   load data (combinational)
//   ram_we, ram_addr, ram_wdata, ram_rdata   data RAM port (async read)
//   sw_in       raw switches (asynchronous, synchronized with 2 flops)
//   led_out     LED register
//   cnt_irq     done & irq_en
//   bus_err     sticky unmapped-write flag
// Handshake: none. Every cycle with cpu_we=1 is a store committed at the next
// clk edge; every cycle is implicitly a load whose data is valid on cpu_rdata
// in that same cycle. There is no stall or ready.
module mio_bus
  import mio_pkg::*;
#(
  parameter int          RAM_ADDR_BITS = 10,
  parameter logic [31:0] IO_BASE       = IO_BASE_DEFAULT,
  parameter int          SW_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata,
  input  logic [SW_WIDTH-1:0]      sw_in,
  output logic [SW_WIDTH-1:0]      led_out,
  output logic                     cnt_irq,
  output logic                     bus_err
);

  logic [SW_WIDTH-1:0]  r_led;
  logic [SW_WIDTH-1:0]  r_sw_s1;
  logic [SW_WIDTH-1:0]  r_sw_s2;
  logic [CTRL_BITS-1:0] r_ctrl;
  logic                 r_bus_err;

  logic                 w_ram_sel;
  logic                 w_io_sel;
  logic [7:0]           w_off;
  logic                 w_io_we;
  logic                 w_unmapped_we;
  logic [31:0]          w_cnt_value;
  logic [31:0]          w_cnt_load;
  logic                 w_done;
  logic [31:0]          w_status;
  logic [31:0]          w_io_rdata;
  logic                 w_unused_addr_lsb;

  // ---------------- decode ----------------
  assign w_ram_sel = (cpu_addr[31:RAM_ADDR_BITS+2] == '0);
  assign w_io_sel  = (cpu_addr[31:8] == IO_BASE[31:8]);
  // Byte offset within the word is dropped so 0xFF03 aliases 0xFF00.
  assign w_off     = {cpu_addr[7:2], 2'b00};
  assign w_unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

  assign w_io_we       = cpu_we && w_io_sel;
  assign w_unmapped_we = cpu_we && !w_ram_sel && !w_io_sel;

  // ---------------- RAM path ----------------
  assign ram_we    = cpu_we && w_ram_sel;
  assign ram_addr  = cpu_addr[RAM_ADDR_BITS+1:2];
  assign ram_wdata = cpu_wdata;

  // ---------------- I/O registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led     <= '0;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_ctrl    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_sw_s1 <= sw_in;
      r_sw_s2 <= r_sw_s1;

      if (w_io_we && (w_off == OFF_LED)) begin
        r_led <= cpu_wdata[SW_WIDTH-1:0];
      end
      if (w_io_we && (w_off == OFF_CTRL)) begin
        r_ctrl <= cpu_wdata[CTRL_BITS-1:0];
      end

      // Set wins over a simultaneous W1C (cannot actually coincide, since a
      // STATUS write is never unmapped, but the priority is kept explicit).
      if (w_unmapped_we) begin
        r_bus_err <= 1'b1;
      end else if (w_io_we && (w_off == OFF_STATUS) && cpu_wdata[STAT_BUS_ERR]) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  mio_counter u_counter (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_load_we     (w_io_we && (w_off == OFF_CNT_LOAD)),
    .i_load_data   (cpu_wdata),
    .i_en          (r_ctrl[CTRL_EN]),
    .i_auto_reload (r_ctrl[CTRL_AUTO_RELOAD]),
    .i_done_clr    (w_io_we && (w_off == OFF_STATUS) && cpu_wdata[STAT_DONE]),
    .o_cnt_value   (w_cnt_value),
    .o_cnt_load    (w_cnt_load),
    .o_done        (w_done)
  );

  // ---------------- read mux ----------------
  always_comb begin
    w_status               = '0;
    w_status[STAT_DONE]    = w_done;
    w_status[STAT_BUS_ERR] = r_bus_err;
  end

  always_comb begin
    w_io_rdata = '0;
    case (w_off)
      OFF_LED:       w_io_rdata = 32'(r_led);
      OFF_SW:        w_io_rdata = 32'(r_sw_s2);
      OFF_CNT_LOAD:  w_io_rdata = w_cnt_load;
      OFF_CNT_VALUE: w_io_rdata = w_cnt_value;
      OFF_CTRL:      w_io_rdata = 32'(r_ctrl);
      OFF_STATUS:    w_io_rdata = w_status;
      default:       w_io_rdata = '0;
    endcase
  end

  always_comb begin
    cpu_rdata = '0;
    if (w_ram_sel) begin
      cpu_rdata = ram_rdata;
    end else if (w_io_sel) begin
      cpu_rdata = w_io_rdata;
    end
  end

  assign led_out = r_led;
  assign bus_err = r_bus_err;
  assign cnt_irq = w_done && r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mio_bus.sv
module tb_mio_bus;

  localparam logic [31:0] A_LED    = 32'hFFFF_FF00;
  localparam logic [31:0] A_SW     = 32'hFFFF_FF04;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_FF08;
  localparam logic [31:0] A_VALUE  = 32'hFFFF_FF0C;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_FF10;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF14;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        cnt_irq;
  logic        bus_err;

  always #5 clk = ~clk;

  mio_bus dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .cnt_irq   (cnt_irq),
    .bus_err   (bus_err)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Commit one bus cycle at the next rising edge; returns 1 time unit after it.
  task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(posedge clk);
    #1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0);
  endtask

  // Combinational read between edges (no clock edge consumed).
  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    cpu_we   = 1'b0;
    cpu_addr = addr;
    #1;
    data     = cpu_rdata;
    cpu_addr = 32'h0;
  endtask

  task automatic peek_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    peek(addr, d);
    chk(name, d, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_rd;
    logic [31:0] exp_rdata;    // before the edge
    logic        exp_ram_we;   // before the edge
    logic [9:0]  exp_ram_addr; // before the edge
    logic [15:0] exp_led;      // after the edge
    logic        exp_bus_err;  // after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rr, input logic [31:0] er, input logic erw,
                     input logic [9:0] era, input logic [15:0] el, input logic eb);
    vec_t v;
    v.name = n; v.we = we; v.addr = a; v.wdata = wd; v.ram_rd = rr;
    v.exp_rdata = er; v.exp_ram_we = erw; v.exp_ram_addr = era;
    v.exp_led = el; v.exp_bus_err = eb;
    vecs.push_back(v);
  endtask

  logic [31:0] d;

  initial begin
    rst       = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    ram_rdata = 32'h0;
    sw_in     = 16'h0;

    //  name        we  addr          wdata         ram_rd        rdata         rwe addr    led      berr
    add("ram_st",   1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        32'h0,        1, 10'h004, 16'h0,    0);
    add("ram_ld",   0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 10'h004, 16'h0,    0);
    add("led_st",   1, A_LED,         32'h0000_A5A5, 32'h0,        32'h0,        0, 10'h3C0, 16'hA5A5, 0);
    add("led_ld",   0, A_LED,         32'h0,        32'h0,        32'h0000_A5A5, 0, 10'h3C0, 16'hA5A5, 0);
    add("led_byte", 0, 32'hFFFF_FF03, 32'h0,        32'h0,        32'h0000_A5A5, 0, 10'h3C0, 16'hA5A5, 0);
    add("unm_st",   1, 32'h1000_0000, 32'h1234_5678, 32'h0,        32'h0,        0, 10'h000, 16'hA5A5, 1);
    add("unm_ld",   0, 32'h1000_0000, 32'h0,        32'hCAFE_F00D, 32'h0,        0, 10'h000, 16'hA5A5, 1);
    add("stat_ld",  0, A_STATUS,      32'h0,        32'h0,        32'h2,        0, 10'h3C5, 16'hA5A5, 1);
    add("stat_w1",  1, A_STATUS,      32'h1,        32'h0,        32'h2,        0, 10'h3C5, 16'hA5A5, 1);
    add("stat_w2",  1, A_STATUS,      32'h2,        32'h0,        32'h2,        0, 10'h3C5, 16'hA5A5, 0);
    add("io_hole",  1, 32'hFFFF_FF40, 32'hFFFF,     32'h0,        32'h0,        0, 10'h3D0, 16'hA5A5, 0);
    add("sw_ro",    1, A_SW,          32'hFFFF,     32'h0,        32'h0,        0, 10'h3C1, 16'hA5A5, 0);
    add("ram_top",  1, 32'h0000_0FFC, 32'h5,        32'h1111_1111, 32'h1111_1111, 1, 10'h3FF, 16'hA5A5, 0);
    add("ram_past", 1, 32'h0000_1000, 32'h5,        32'h2222_2222, 32'h0,        0, 10'h000, 16'hA5A5, 1);
    add("stat_w3",  1, A_STATUS,      32'h3,        32'h0,        32'h2,        0, 10'h3C5, 16'hA5A5, 0);
    add("below_io", 0, 32'hFFFF_FE00, 32'h0,        32'h3333_3333, 32'h0,        0, 10'h380, 16'hA5A5, 0);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_irq", 32'(cnt_irq), 32'h0);
    chk("rst_berr", 32'(bus_err), 32'h0);
    peek_chk("rst_value", A_VALUE, 32'h0);
    peek_chk("rst_ctrl", A_CTRL, 32'h0);
    peek_chk("rst_status", A_STATUS, 32'h0);

    // ---------------- table-driven vectors ----------------
    foreach (vecs[i]) begin
      cpu_we    = vecs[i].we;
      cpu_addr  = vecs[i].addr;
      cpu_wdata = vecs[i].wdata;
      ram_rdata = vecs[i].ram_rd;
      @(negedge clk);
      chk({vecs[i].name, ".rdata"}, cpu_rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, ".ram_we"}, 32'(ram_we), 32'(vecs[i].exp_ram_we));
      chk({vecs[i].name, ".ram_addr"}, 32'(ram_addr), 32'(vecs[i].exp_ram_addr));
      if (vecs[i].we) chk({vecs[i].name, ".ram_wdata"}, ram_wdata, vecs[i].wdata);
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".led"}, 32'(led_out), 32'(vecs[i].exp_led));
      chk({vecs[i].name, ".bus_err"}, 32'(bus_err), 32'(vecs[i].exp_bus_err));
      chk({vecs[i].name, ".irq"}, 32'(cnt_irq), 32'h0);
      cpu_we    = 1'b0;
      ram_rdata = 32'h0;
    end

    // ---------------- switch synchronizer ----------------
    sw_in = 16'h1234;
    peek_chk("sw_edge0", A_SW, 32'h0);
    idle();
    peek_chk("sw_edge1", A_SW, 32'h0);
    idle();
    peek_chk("sw_edge2", A_SW, 32'h0000_1234);
    idle();
    peek_chk("sw_edge3", A_SW, 32'h0000_1234);

    // ---------------- one-shot counter ----------------
    cyc(1'b1, A_LOAD, 32'd3);
    peek_chk("os_load", A_VALUE, 32'd3);
    cyc(1'b1, A_CTRL, 32'h5);         // en not yet active on this edge
    peek_chk("os_ctrl_edge", A_VALUE, 32'd3);
    peek_chk("os_ctrl_rd", A_CTRL, 32'h5);
    idle();
    peek_chk("os_v2", A_VALUE, 32'd2);
    idle();
    peek_chk("os_v1", A_VALUE, 32'd1);
    chk("os_irq_pre", 32'(cnt_irq), 32'h0);
    idle();
    peek_chk("os_v0", A_VALUE, 32'd0);
    peek_chk("os_done", A_STATUS, 32'h1);
    chk("os_irq", 32'(cnt_irq), 32'h1);
    idle();
    peek_chk("os_hold", A_VALUE, 32'd0);
    chk("os_irq_hold", 32'(cnt_irq), 32'h1);
    cyc(1'b1, A_STATUS, 32'h1);
    peek_chk("os_clr", A_STATUS, 32'h0);
    chk("os_irq_clr", 32'(cnt_irq), 32'h0);
    idle();
    peek_chk("os_no_reset_done", A_STATUS, 32'h0);

    // ---------------- auto-reload with collisions ----------------
    cyc(1'b1, A_CTRL, 32'h0);
    cyc(1'b1, A_LOAD, 32'd2);
    cyc(1'b1, A_CTRL, 32'h3);
    peek_chk("ar_v2a", A_VALUE, 32'd2);
    idle();
    peek_chk("ar_v1a", A_VALUE, 32'd1);
    peek_chk("ar_done_pre", A_STATUS, 32'h0);
    cyc(1'b1, A_STATUS, 32'h1);       // W1C on the reload edge
    peek_chk("ar_v2b", A_VALUE, 32'd2);
    peek_chk("ar_set_wins", A_STATUS, 32'h1);
    chk("ar_irq_masked", 32'(cnt_irq), 32'h0);
    idle();
    peek_chk("ar_v1b", A_VALUE, 32'd1);
    idle();
    peek_chk("ar_v2c", A_VALUE, 32'd2);
    cyc(1'b1, A_LOAD, 32'd7);         // load beats the decrement
    peek_chk("ar_load7", A_VALUE, 32'd7);
    peek_chk("ar_load7_reg", A_LOAD, 32'd7);
    idle();
    peek_chk("ar_v6", A_VALUE, 32'd6);

    // ---------------- reset mid-count ----------------
    cyc(1'b1, A_LOAD, 32'd100);
    cyc(1'b1, A_CTRL, 32'h7);
    cyc(1'b1, A_LED, 32'hFFFF);
    cyc(1'b1, 32'h1000_0000, 32'h0);
    peek_chk("mid_value", A_VALUE, 32'd97);
    chk("mid_berr", 32'(bus_err), 32'h1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    peek_chk("mr_value", A_VALUE, 32'h0);
    peek_chk("mr_load", A_LOAD, 32'h0);
    peek_chk("mr_ctrl", A_CTRL, 32'h0);
    peek_chk("mr_status", A_STATUS, 32'h0);
    peek_chk("mr_sw", A_SW, 32'h0);
    chk("mr_led", 32'(led_out), 32'h0);
    chk("mr_berr", 32'(bus_err), 32'h0);
    chk("mr_irq", 32'(cnt_irq), 32'h0);
    idle();
    peek_chk("mr_hold", A_VALUE, 32'h0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
